// File: rtl/pe_net_iface_pkg.sv
// Shared NoC constants: flit field widths, statistics counter width and
// saturation value, plus the saturating counter update used by the PE interface.
package pe_net_iface_pkg;

    localparam int NOC_DATA_W = 36;  // full flit width
    localparam int NOC_ADDR_W = 4;   // destination field width (flit MSBs)
    localparam int NOC_CNT_W  = 16;  // statistics counter width

    localparam logic [NOC_CNT_W-1:0] NOC_CNT_SAT = 16'hFFFF;

    // Clear has priority; otherwise count up, sticking at the saturation value.
    function automatic logic [NOC_CNT_W-1:0] cnt_next(
        input logic [NOC_CNT_W-1:0] cnt,
        input logic                 inc,
        input logic                 clr
    );
        if (clr) begin
            return '0;
        end else if (inc && (cnt != NOC_CNT_SAT)) begin
            return cnt + NOC_CNT_W'(1);
        end else begin
            return cnt;
        end
    endfunction

endpackage

// File: rtl/pe_net_iface_fifo.sv
// noc_sync_fifo: single-clock FIFO with valid/ready on both sides.
// Handshake: a beat moves only in a cycle where valid and ready are both high;
// the sender keeps valid and data stable until that cycle.
// in_ready_o and out_valid_o come straight from the pointer registers, so
// neither depends on the same-cycle activity of the other side.
module noc_sync_fifo #(
    parameter int Width = 32,
    parameter int Depth = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [Width-1:0] in_data_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    output logic [Width-1:0] out_data_o,
    output logic             out_valid_o,
    input  logic             out_ready_i
);

    localparam int PtrW = $clog2(Depth);

    // Pointers carry one extra wrap bit to tell full from empty.
    logic [PtrW:0]    wr_ptr_q, wr_ptr_d;
    logic [PtrW:0]    rd_ptr_q, rd_ptr_d;
    logic [Width-1:0] mem_q [Depth];
    logic             full, empty, push, pop;

    assign full  = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                   (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign push  = in_valid_i && !full;
    assign pop   = !empty && out_ready_i;

    assign in_ready_o  = !full;
    assign out_valid_o = !empty;
    // Head is forced to zero while empty so data outputs read 0 after reset.
    assign out_data_o  = empty ? '0 : mem_q[rd_ptr_q[PtrW-1:0]];

    // Pointer advance on each accepted push / pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) wr_ptr_d = wr_ptr_q + (PtrW+1)'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + (PtrW+1)'(1);
    end

    // Pointer registers; reset empties the FIFO.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage write; contents are don't-care until the pointers cover them.
    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q[PtrW-1:0]] <= in_data_i;
    end

endmodule

// File: rtl/pe_net_iface.sv
// pe_net_iface: bridges a processing element to its leaf-switch port.
// TX: PE payload + destination packed into a flit and queued toward the net.
// RX: flits addressed to this PE are queued for the PE; all others are
// accepted and discarded. Both paths run independently; 16-bit saturating
// statistics count sent, delivered and dropped flits.
module pe_net_iface
    import pe_net_iface_pkg::*;
#(
    parameter int DataWidth = NOC_DATA_W,
    parameter int AddrWidth = NOC_ADDR_W,
    parameter int MyAddr    = 0,
    parameter int FifoDepth = 4
) (
    input  logic                           i_clk,
    input  logic                           i_reset,
    input  logic [DataWidth-AddrWidth-1:0] i_pe_data,
    input  logic [AddrWidth-1:0]           i_pe_dest,
    input  logic                           i_pe_valid,
    output logic                           o_pe_ready,
    output logic [DataWidth-AddrWidth-1:0] o_pe_data,
    output logic                           o_pe_valid,
    input  logic                           i_pe_ready,
    output logic [DataWidth-1:0]           o_net_data,
    output logic                           o_net_data_valid,
    input  logic                           i_net_data_ready,
    input  logic [DataWidth-1:0]           i_net_data,
    input  logic                           i_net_data_valid,
    output logic                           o_net_data_ready,
    input  logic                           i_clr_counts,
    output logic [NOC_CNT_W-1:0]           o_tx_count,
    output logic [NOC_CNT_W-1:0]           o_rx_count,
    output logic [NOC_CNT_W-1:0]           o_drop_count
);

    localparam int PayloadWidth = DataWidth - AddrWidth;

    logic                   rx_in_ready;
    logic                   dest_match;
    logic                   tx_hs, rx_push, rx_drop;
    logic [NOC_CNT_W-1:0]   tx_cnt_q, tx_cnt_d;
    logic [NOC_CNT_W-1:0]   rx_cnt_q, rx_cnt_d;
    logic [NOC_CNT_W-1:0]   drop_cnt_q, drop_cnt_d;

    // TX queue: flit = {dest, payload}; own-address flits go out unchanged.
    noc_sync_fifo #(
        .Width (DataWidth),
        .Depth (FifoDepth)
    ) u_tx_fifo (
        .clk_i       (i_clk),
        .rst_ni      (i_reset),
        .in_data_i   ({i_pe_dest, i_pe_data}),
        .in_valid_i  (i_pe_valid),
        .in_ready_o  (o_pe_ready),
        .out_data_o  (o_net_data),
        .out_valid_o (o_net_data_valid),
        .out_ready_i (i_net_data_ready)
    );

    // Readiness toward the net depends only on RX fullness, never on the
    // destination, so misaddressed flits are always consumed.
    assign dest_match       = (i_net_data[DataWidth-1 -: AddrWidth] == AddrWidth'(MyAddr));
    assign o_net_data_ready = rx_in_ready;
    assign rx_push          = i_net_data_valid && rx_in_ready && dest_match;
    assign rx_drop          = i_net_data_valid && rx_in_ready && !dest_match;
    assign tx_hs            = o_net_data_valid && i_net_data_ready;

    // RX queue holds payload only; the destination field is stripped.
    noc_sync_fifo #(
        .Width (PayloadWidth),
        .Depth (FifoDepth)
    ) u_rx_fifo (
        .clk_i       (i_clk),
        .rst_ni      (i_reset),
        .in_data_i   (i_net_data[PayloadWidth-1:0]),
        .in_valid_i  (i_net_data_valid && dest_match),
        .in_ready_o  (rx_in_ready),
        .out_data_o  (o_pe_data),
        .out_valid_o (o_pe_valid),
        .out_ready_i (i_pe_ready)
    );

    // Statistics next-state: clear beats increment, counts saturate.
    always_comb begin
        tx_cnt_d   = cnt_next(tx_cnt_q,   tx_hs,   i_clr_counts);
        rx_cnt_d   = cnt_next(rx_cnt_q,   rx_push, i_clr_counts);
        drop_cnt_d = cnt_next(drop_cnt_q, rx_drop, i_clr_counts);
    end

    // Statistics registers.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            tx_cnt_q   <= '0;
            rx_cnt_q   <= '0;
            drop_cnt_q <= '0;
        end else begin
            tx_cnt_q   <= tx_cnt_d;
            rx_cnt_q   <= rx_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign o_tx_count   = tx_cnt_q;
    assign o_rx_count   = rx_cnt_q;
    assign o_drop_count = drop_cnt_q;

endmodule

// File: tb/tb_pe_net_iface.sv
// Bench for pe_net_iface (MyAddr = 2): table-driven TX and RX vectors,
// hand-written backpressure, concurrency, saturation and reset sequences.
module tb_pe_net_iface;

  localparam int DW = 36;
  localparam int AW = 4;
  localparam int PW = DW - AW;
  localparam logic [AW-1:0] MY = 4'h2;

  // ---------------- clock / reset ----------------
  logic          i_clk = 1'b0;
  logic          i_reset = 1'b0;
  logic [PW-1:0] i_pe_data;
  logic [AW-1:0] i_pe_dest;
  logic          i_pe_valid;
  logic          o_pe_ready;
  logic [PW-1:0] o_pe_data;
  logic          o_pe_valid;
  logic          i_pe_ready;
  logic [DW-1:0] o_net_data;
  logic          o_net_data_valid;
  logic          i_net_data_ready;
  logic [DW-1:0] i_net_data;
  logic          i_net_data_valid;
  logic          o_net_data_ready;
  logic          i_clr_counts;
  logic [15:0]   o_tx_count, o_rx_count, o_drop_count;

  always #5 i_clk = ~i_clk;

  pe_net_iface #(
    .DataWidth (DW),
    .AddrWidth (AW),
    .MyAddr    (2),
    .FifoDepth (4)
  ) dut (
    .i_clk            (i_clk),
    .i_reset          (i_reset),
    .i_pe_data        (i_pe_data),
    .i_pe_dest        (i_pe_dest),
    .i_pe_valid       (i_pe_valid),
    .o_pe_ready       (o_pe_ready),
    .o_pe_data        (o_pe_data),
    .o_pe_valid       (o_pe_valid),
    .i_pe_ready       (i_pe_ready),
    .o_net_data       (o_net_data),
    .o_net_data_valid (o_net_data_valid),
    .i_net_data_ready (i_net_data_ready),
    .i_net_data       (i_net_data),
    .i_net_data_valid (i_net_data_valid),
    .o_net_data_ready (o_net_data_ready),
    .i_clr_counts     (i_clr_counts),
    .o_tx_count       (o_tx_count),
    .o_rx_count       (o_rx_count),
    .o_drop_count     (o_drop_count)
  );

  // ---------------- scoreboard state ----------------
  int errors = 0;
  int checks = 0;
  logic [DW-1:0] tx_exp_q[$];
  logic [PW-1:0] rx_exp_q[$];
  logic [DW-1:0] tx_e;
  logic [PW-1:0] rx_e;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: condition not met within bound", name);
  endtask

  // TX monitor: flit leaving toward the net must match the oldest expected.
  always @(negedge i_clk) begin
    if (i_reset && o_net_data_valid && i_net_data_ready) begin
      if (tx_exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL tx_unexpected: got %0h expected no flit", o_net_data);
      end else begin
        tx_e = tx_exp_q.pop_front();
        check("tx_flit", 64'(o_net_data), 64'(tx_e));
      end
    end
  end

  // RX monitor: payload delivered to the PE must match the oldest expected.
  always @(negedge i_clk) begin
    if (i_reset && o_pe_valid && i_pe_ready) begin
      if (rx_exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rx_unexpected: got %0h expected no payload", o_pe_data);
      end else begin
        rx_e = rx_exp_q.pop_front();
        check("rx_payload", 64'(o_pe_data), 64'(rx_e));
      end
    end
  end

  // Watchdog.
  initial begin
    repeat (200000) @(posedge i_clk);
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  task automatic pe_send(input logic [AW-1:0] dest, input logic [PW-1:0] pl,
                         input logic [DW-1:0] exp_flit);
    int n;
    logic rdy;
    i_pe_dest  = dest;
    i_pe_data  = pl;
    i_pe_valid = 1'b1;
    n = 0;
    do begin
      @(negedge i_clk);
      rdy = o_pe_ready;
      @(posedge i_clk);
      n++;
    end while (!rdy && n < 50);
    if (rdy) tx_exp_q.push_back(exp_flit);
    else fail_now("pe_send_accept");
    #1;
    i_pe_valid = 1'b0;
  endtask

  task automatic net_send(input logic [DW-1:0] flit, input logic deliver,
                          input logic [PW-1:0] exp_pl);
    int n;
    logic rdy;
    i_net_data       = flit;
    i_net_data_valid = 1'b1;
    n = 0;
    do begin
      @(negedge i_clk);
      rdy = o_net_data_ready;
      @(posedge i_clk);
      n++;
    end while (!rdy && n < 50);
    if (!rdy) fail_now("net_send_accept");
    else if (deliver) rx_exp_q.push_back(exp_pl);
    #1;
    i_net_data_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((tx_exp_q.size() != 0 || rx_exp_q.size() != 0) && n < 60) begin
      tick(1);
      n++;
    end
    if (tx_exp_q.size() != 0 || rx_exp_q.size() != 0) fail_now(name);
    tick(1);
  endtask

  task automatic clr_counts();
    i_clr_counts = 1'b1;
    tick(1);
    i_clr_counts = 1'b0;
  endtask

  // ---------------- vector tables ----------------
  typedef struct packed {
    logic [AW-1:0] dest;
    logic [PW-1:0] pl;
    logic [DW-1:0] exp_flit;
  } tx_vec_t;

  typedef struct packed {
    logic [DW-1:0] flit;
    logic          deliver;
    logic [PW-1:0] exp_pl;
  } rx_vec_t;

  tx_vec_t tx_tab[4];
  rx_vec_t rx_tab[6];

  // ---------------- test sequence ----------------
  initial begin
    int cnt;

    tx_tab[0] = '{4'h3, 32'hDEADBEEF, 36'h3DEADBEEF};
    tx_tab[1] = '{4'h2, 32'h00000001, 36'h200000001};  // own address, forwarded
    tx_tab[2] = '{4'hF, 32'hFFFFFFFF, 36'hFFFFFFFFF};
    tx_tab[3] = '{4'h0, 32'h12345678, 36'h012345678};

    rx_tab[0] = '{36'h2000000AA, 1'b1, 32'h000000AA};
    rx_tab[1] = '{36'h5000000BB, 1'b0, 32'h0};
    rx_tab[2] = '{36'h212345678, 1'b1, 32'h12345678};
    rx_tab[3] = '{36'h0CAFEF00D, 1'b0, 32'h0};
    rx_tab[4] = '{36'hFFFFFFFFF, 1'b0, 32'h0};
    rx_tab[5] = '{36'h2FFFFFFFF, 1'b1, 32'hFFFFFFFF};

    i_pe_data = '0; i_pe_dest = '0; i_pe_valid = 1'b0; i_pe_ready = 1'b1;
    i_net_data = '0; i_net_data_valid = 1'b0; i_net_data_ready = 1'b1;
    i_clr_counts = 1'b0;

    // Reset state.
    tick(3);
    @(negedge i_clk);
    check("rst_pe_ready",  64'(o_pe_ready), 64'd1);
    check("rst_net_ready", 64'(o_net_data_ready), 64'd1);
    check("rst_net_valid", 64'(o_net_data_valid), 64'd0);
    check("rst_pe_valid",  64'(o_pe_valid), 64'd0);
    check("rst_net_data",  64'(o_net_data), 64'd0);
    check("rst_pe_data",   64'(o_pe_data), 64'd0);
    check("rst_counts",    {16'd0, o_tx_count, o_rx_count, o_drop_count}, 64'd0);
    @(posedge i_clk); #1;
    i_reset = 1'b1;
    tick(1);

    // Single TX, latency 1.
    pe_send(4'h3, 32'hDEADBEEF, 36'h3DEADBEEF);
    @(negedge i_clk);
    check("single_tx_valid", 64'(o_net_data_valid), 64'd1);
    check("single_tx_data",  64'(o_net_data), 64'h3DEADBEEF);
    tick(1);
    @(negedge i_clk);
    check("single_tx_count", 64'(o_tx_count), 64'd1);
    check("single_tx_empty", 64'(o_net_data_valid), 64'd0);
    tick(1);

    // TX table.
    for (int i = 0; i < 4; i++) pe_send(tx_tab[i].dest, tx_tab[i].pl, tx_tab[i].exp_flit);
    drain("tx_table_drain");
    @(negedge i_clk);
    check("tx_table_count", 64'(o_tx_count), 64'd5);
    tick(1);

    // Backpressure: 4 fill the queue, 5th waits until the net drains.
    clr_counts();
    i_net_data_ready = 1'b0;
    for (int i = 0; i < 4; i++) pe_send(4'h1, 32'hA0 + 32'(i), {4'h1, 32'hA0 + 32'(i)});
    @(negedge i_clk);
    check("bp_full_ready", 64'(o_pe_ready), 64'd0);
    @(posedge i_clk); #1;
    fork
      pe_send(4'h1, 32'hA4, 36'h1000000A4);
      begin
        repeat (3) begin
          @(negedge i_clk);
          check("bp_hold_ready", 64'(o_pe_ready), 64'd0);
          check("bp_hold_valid", 64'(o_net_data_valid), 64'd1);
        end
        @(posedge i_clk); #1;
        i_net_data_ready = 1'b1;
      end
    join
    drain("bp_drain");
    @(negedge i_clk);
    check("bp_tx_count", 64'(o_tx_count), 64'd5);
    tick(1);

    // RX filter table.
    clr_counts();
    for (int i = 0; i < 6; i++) net_send(rx_tab[i].flit, rx_tab[i].deliver, rx_tab[i].exp_pl);
    drain("rx_table_drain");
    @(negedge i_clk);
    check("rx_table_rx_count",   64'(o_rx_count), 64'd3);
    check("rx_table_drop_count", 64'(o_drop_count), 64'd3);
    tick(1);

    // Concurrent push/pop with two entries resident.
    clr_counts();
    i_pe_ready = 1'b0;
    net_send({MY, 32'h100}, 1'b1, 32'h100);
    net_send({MY, 32'h101}, 1'b1, 32'h101);
    @(negedge i_clk);
    check("conc_head_valid", 64'(o_pe_valid), 64'd1);
    check("conc_head_data",  64'(o_pe_data), 64'h100);
    @(posedge i_clk); #1;
    for (int k = 0; k < 20; k++) begin
      i_pe_ready       = 1'b1;
      i_net_data       = {MY, 32'h200 + 32'(k)};
      i_net_data_valid = 1'b1;
      rx_exp_q.push_back(32'h200 + 32'(k));
      @(negedge i_clk);
      check("conc_net_ready", 64'(o_net_data_ready), 64'd1);
      check("conc_pe_valid",  64'(o_pe_valid), 64'd1);
      @(posedge i_clk); #1;
    end
    i_net_data_valid = 1'b0;
    cnt = 0;
    repeat (6) begin
      @(negedge i_clk);
      if (o_pe_valid) cnt++;
      @(posedge i_clk); #1;
    end
    check("conc_occupancy", 64'(cnt), 64'd2);
    check("conc_queue_left", 64'(rx_exp_q.size()), 64'd0);
    @(negedge i_clk);
    check("conc_rx_count", 64'(o_rx_count), 64'd22);
    tick(1);

    // Drop counter saturation and clear priority.
    clr_counts();
    i_net_data       = {4'h7, 32'h0};
    i_net_data_valid = 1'b1;
    repeat (65534) @(posedge i_clk);
    #1;
    i_net_data_valid = 1'b0;
    @(negedge i_clk);
    check("sat_preload", 64'(o_drop_count), 64'hFFFE);
    @(posedge i_clk); #1;
    i_net_data_valid = 1'b1;
    tick(3);
    i_net_data_valid = 1'b0;
    @(negedge i_clk);
    check("sat_hold", 64'(o_drop_count), 64'hFFFF);
    @(posedge i_clk); #1;
    i_net_data_valid = 1'b1;
    i_clr_counts     = 1'b1;
    tick(1);
    i_net_data_valid = 1'b0;
    i_clr_counts     = 1'b0;
    @(negedge i_clk);
    check("sat_clr_wins", 64'(o_drop_count), 64'd0);
    check("sat_rx_count", 64'(o_rx_count), 64'd0);
    tick(1);

    // Reset mid-burst with 3 TX flits queued.
    pe_send(4'h9, 32'h11, 36'h900000011);
    drain("pre_reset_drain");
    i_net_data_ready = 1'b0;
    for (int i = 0; i < 3; i++) pe_send(4'h6, 32'hC0 + 32'(i), {4'h6, 32'hC0 + 32'(i)});
    i_reset = 1'b0;
    tx_exp_q.delete();
    rx_exp_q.delete();
    @(negedge i_clk);
    check("mid_rst_valid",   64'(o_net_data_valid), 64'd0);
    check("mid_rst_data",    64'(o_net_data), 64'd0);
    check("mid_rst_ready",   64'(o_pe_ready), 64'd1);
    check("mid_rst_tx_cnt",  64'(o_tx_count), 64'd0);
    @(posedge i_clk); #1;
    i_net_data_ready = 1'b1;
    tick(1);
    i_reset = 1'b1;
    @(negedge i_clk);
    check("post_rst_valid0", 64'(o_net_data_valid), 64'd0);
    @(posedge i_clk); #1;
    @(negedge i_clk);
    check("post_rst_valid1", 64'(o_net_data_valid), 64'd0);
    @(posedge i_clk); #1;
    pe_send(4'h4, 32'h55, 36'h400000055);
    drain("post_rst_drain");
    @(negedge i_clk);
    check("post_rst_tx_cnt", 64'(o_tx_count), 64'd1);
    tick(1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
